reg_dump_unit: RTL and testbench

- Synthesizable successor to the fixed-cycle register-dump check used around the single-cycle CPU.
- After a programmable cycle count, or on a start pulse, it walks the register file's read port, register index 0 to NUM_REGS-1.
- Each entry is streamed out on a valid/ready interface to a trace sink (UART or scan logic).
- Sits beside the CPU register file and uses a dedicated third read port.
- Supports one-shot and periodic dump modes.

---
 rtl/reg_dump_unit.sv | 110 +++++++++++
 tb/tb_reg_dump_unit.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_unit.sv
// Register-file dump engine: walks RF indices 0..NUM_REGS-1 after a programmed
// cycle count or a start pulse, and streams each entry out over valid/ready.
module reg_dump_unit #(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 13,
  parameter int IDX_W     = 5,
  parameter int CNT_W     = 16,
  parameter int END_COUNT = 14,
  parameter int PERIODIC  = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic [IDX_W-1:0]  rf_addr_o,
  input  logic [DATA_W-1:0] rf_data_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [IDX_W-1:0]  dump_idx_o,
  output logic [DATA_W-1:0] dump_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  cycle_cnt_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_SEND  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  localparam logic [CNT_W-1:0] TRIG_CNT = CNT_W'((END_COUNT == 0) ? 0 : END_COUNT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  logic [2:0]        r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_valid;
  logic [IDX_W-1:0]  r_didx;
  logic [DATA_W-1:0] r_data;

  logic w_auto;
  logic w_clr;

  assign w_auto = (END_COUNT != 0) && (r_cnt == TRIG_CNT);
  assign w_clr  = (r_state == S_DONE) && (PERIODIC != 0);

  // RF address follows the walk index; it only moves on trigger or accept,
  // so it is stable (and deterministic) outside FETCH.
  assign rf_addr_o    = r_idx;
  assign dump_valid_o = r_valid;
  assign dump_idx_o   = r_didx;
  assign dump_data_o  = r_data;
  assign cycle_cnt_o  = r_cnt;
  assign done_o       = (r_state == S_DONE);
  assign busy_o       = (r_state == S_FETCH) || (r_state == S_SEND) || (r_state == S_DONE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_didx  <= '0;
      r_data  <= '0;
    end else begin
      if (w_clr)
        r_cnt <= '0;
      else if (r_cnt != '1)
        r_cnt <= r_cnt + CNT_W'(1);

      case (r_state)
        S_IDLE: begin
          if (start_i || w_auto) begin
            r_idx   <= '0;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_data  <= rf_data_i;
          r_didx  <= r_idx;
          r_valid <= 1'b1;
          r_state <= S_SEND;
        end
        S_SEND: begin
          // valid is registered, so ready never reaches it combinationally
          if (dump_ready_i) begin
            r_valid <= 1'b0;
            if (r_idx == LAST_IDX) begin
              r_state <= S_DONE;
            end else begin
              r_idx   <= r_idx + IDX_W'(1);
              r_state <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          r_state <= (PERIODIC != 0) ? S_IDLE : S_HALT;
        end
        S_HALT: begin
          if (start_i) begin
            r_idx   <= '0;
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_unit.sv
// Bench for reg_dump_unit: four parameterisations share clock, reset and a
// model register file; transfers are logged with their edge number and checked.
module tb_reg_dump_unit;

  typedef struct {
    int          e;
    logic [4:0]  idx;
    logic [31:0] d;
  } xfer_t;

  logic             clk;
  logic             rst;
  logic [3:0]       start;
  logic [3:0]       rdy;
  logic [3:0]       dv;
  logic [3:0]       busy;
  logic [3:0]       done;
  logic [3:0][4:0]  addr;
  logic [3:0][4:0]  didx;
  logic [3:0][31:0] rdata;
  logic [3:0][31:0] ddata;
  logic [15:0]      cnt0, cnt1, cnt3;
  logic [3:0]       cnt2;
  logic [31:0]      rf [32];

  int    vecs, errs, edge_n, sel;
  xfer_t xq[$];
  int    dq[$];

  always_comb
    for (int i = 0; i < 4; i++) rdata[i] = rf[addr[i]];

  reg_dump_unit u0 (
    .clk_i(clk), .rst_i(rst), .start_i(start[0]), .rf_addr_o(addr[0]), .rf_data_i(rdata[0]),
    .dump_valid_o(dv[0]), .dump_ready_i(rdy[0]), .dump_idx_o(didx[0]), .dump_data_o(ddata[0]),
    .busy_o(busy[0]), .done_o(done[0]), .cycle_cnt_o(cnt0));

  reg_dump_unit #(.PERIODIC(1)) u1 (
    .clk_i(clk), .rst_i(rst), .start_i(start[1]), .rf_addr_o(addr[1]), .rf_data_i(rdata[1]),
    .dump_valid_o(dv[1]), .dump_ready_i(rdy[1]), .dump_idx_o(didx[1]), .dump_data_o(ddata[1]),
    .busy_o(busy[1]), .done_o(done[1]), .cycle_cnt_o(cnt1));

  reg_dump_unit #(.END_COUNT(0), .CNT_W(4)) u2 (
    .clk_i(clk), .rst_i(rst), .start_i(start[2]), .rf_addr_o(addr[2]), .rf_data_i(rdata[2]),
    .dump_valid_o(dv[2]), .dump_ready_i(rdy[2]), .dump_idx_o(didx[2]), .dump_data_o(ddata[2]),
    .busy_o(busy[2]), .done_o(done[2]), .cycle_cnt_o(cnt2));

  reg_dump_unit #(.NUM_REGS(1), .END_COUNT(3)) u3 (
    .clk_i(clk), .rst_i(rst), .start_i(start[3]), .rf_addr_o(addr[3]), .rf_data_i(rdata[3]),
    .dump_valid_o(dv[3]), .dump_ready_i(rdy[3]), .dump_idx_o(didx[3]), .dump_data_o(ddata[3]),
    .busy_o(busy[3]), .done_o(done[3]), .cycle_cnt_o(cnt3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: log a handshake seen just before the edge and a done pulse after it.
  task automatic tick();
    logic        hs;
    logic [4:0]  pi;
    logic [31:0] pd;
    hs = dv[sel] && rdy[sel];
    pi = didx[sel];
    pd = ddata[sel];
    @(posedge clk); #1;
    edge_n++;
    if (hs) xq.push_back('{edge_n, pi, pd});
    if (done[sel]) dq.push_back(edge_n);
  endtask

  task automatic run_to(input int e);
    while (edge_n < e) tick();
  endtask

  task automatic rf_linear();
    for (int k = 0; k < 32; k++) rf[k] = 32'(3 * k);
  endtask

  task automatic do_reset();
    rst = 1'b1; start = '0; rdy = '1;
    #12;
    @(negedge clk);
    rst = 1'b0;
    edge_n = 0;
    xq.delete();
    dq.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = '0; rdy = '1;
    #3;
    vecs++;
    if ({dv, busy, done} !== 12'h0) begin
      errs++; $display("FAIL reset_ctl: got %h want 000", {dv, busy, done});
    end
    vecs++;
    if ({addr, didx, ddata} !== '0) begin
      errs++; $display("FAIL reset_data: got %h want 0", {addr, didx, ddata});
    end
    vecs++;
    if ({cnt0, cnt1, cnt2, cnt3} !== '0) begin
      errs++; $display("FAIL reset_cnt: got %h want 0", {cnt0, cnt1, cnt2, cnt3});
    end
  endtask

  task automatic test_basic();
    sel = 0; rf_linear(); do_reset();
    run_to(14);
    vecs++;
    if (dv[0] !== 1'b0) begin errs++; $display("FAIL basic_early_valid: got %b want 0", dv[0]); end
    tick();
    vecs++;
    if ({dv[0], didx[0], ddata[0]} !== {1'b1, 5'd0, 32'd0}) begin
      errs++; $display("FAIL basic_first: got %b/%0d/%0d want 1/0/0", dv[0], didx[0], ddata[0]);
    end
    run_to(41);
    vecs++;
    if (busy[0] !== 1'b0) begin errs++; $display("FAIL basic_halt: busy=%b want 0", busy[0]); end
    run_to(61);
    vecs++;
    if (xq.size() != 13) begin errs++; $display("FAIL basic_count: got %0d want 13", xq.size()); end
    for (int k = 0; k < 13 && k < xq.size(); k++) begin
      vecs++;
      if (xq[k].e != 16 + 2*k || xq[k].idx !== 5'(k) || xq[k].d !== 32'(3*k)) begin
        errs++; $display("FAIL basic_entry%0d: got e%0d/%0d/%0d want e%0d/%0d/%0d",
                         k, xq[k].e, xq[k].idx, xq[k].d, 16 + 2*k, k, 3*k);
      end
    end
    vecs++;
    if (dq.size() != 1 || dq[0] != 40) begin
      errs++; $display("FAIL basic_done: got n=%0d first=%0d want n=1 at 40", dq.size(), (dq.size() > 0) ? dq[0] : -1);
    end
    // restart from HALT with a start pulse
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    tick();
    vecs++;
    if ({dv[0], didx[0]} !== {1'b1, 5'd0}) begin
      errs++; $display("FAIL halt_restart: got %b/%0d want 1/0", dv[0], didx[0]);
    end
  endtask

  task automatic test_backpressure();
    sel = 0; rf_linear(); do_reset();
    while (edge_n < 60) begin
      rdy[0] = !(edge_n >= 23 && edge_n <= 27);
      tick();
      if (edge_n >= 24 && edge_n <= 28) begin
        vecs++;
        if ({dv[0], didx[0], ddata[0]} !== {1'b1, 5'd4, 32'd12}) begin
          errs++; $display("FAIL bp_hold@%0d: got %b/%0d/%0d want 1/4/12", edge_n, dv[0], didx[0], ddata[0]);
        end
      end
    end
    rdy[0] = 1'b1;
    vecs++;
    if (xq.size() != 13) begin errs++; $display("FAIL bp_count: got %0d want 13", xq.size()); end
    else begin
      vecs++;
      if (xq[4].e != 29 || xq[4].idx !== 5'd4 || xq[5].idx !== 5'd5 || xq[12].e != 45) begin
        errs++; $display("FAIL bp_timing: got e4=%0d idx4=%0d idx5=%0d e12=%0d want 29/4/5/45",
                         xq[4].e, xq[4].idx, xq[5].idx, xq[12].e);
      end
    end
    vecs++;
    if (dq.size() != 1 || dq[0] != 45) begin errs++; $display("FAIL bp_done: got n=%0d want 1 at 45", dq.size()); end
  endtask

  task automatic test_periodic();
    logic [31:0] snap [13];
    sel = 1; rf_linear(); do_reset();
    run_to(41);
    vecs++;
    if (cnt1 !== 16'd0) begin errs++; $display("FAIL per_clear: got %0d want 0", cnt1); end
    for (int k = 0; k < 13; k++) begin rf[k] = $urandom; snap[k] = rf[k]; end
    run_to(54);
    vecs++;
    if (busy[1] !== 1'b0) begin errs++; $display("FAIL per_idle54: busy=%b want 0", busy[1]); end
    tick();
    vecs++;
    if (busy[1] !== 1'b1) begin errs++; $display("FAIL per_fetch55: busy=%b want 1", busy[1]); end
    run_to(90);
    vecs++;
    if (xq.size() != 26) begin errs++; $display("FAIL per_count: got %0d want 26", xq.size()); end
    for (int k = 0; k < 13 && 13 + k < xq.size(); k++) begin
      vecs++;
      if (xq[13+k].e != 57 + 2*k || xq[13+k].idx !== 5'(k) || xq[13+k].d !== snap[k]) begin
        errs++; $display("FAIL per_entry%0d: got e%0d/%0d/%h want e%0d/%0d/%h",
                         k, xq[13+k].e, xq[13+k].idx, xq[13+k].d, 57 + 2*k, k, snap[k]);
      end
    end
    vecs++;
    if (dq.size() != 2 || dq[0] != 40 || dq[1] != 81) begin
      errs++; $display("FAIL per_done: got n=%0d want 2 at 40,81", dq.size());
    end
  endtask

  task automatic test_start();
    sel = 2; do_reset();
    for (int k = 0; k < 32; k++) rf[k] = $urandom;
    run_to(20);
    vecs++;
    if (xq.size() != 0 || busy[2] !== 1'b0) begin
      errs++; $display("FAIL st_nodump: got n=%0d busy=%b want 0/0", xq.size(), busy[2]);
    end
    vecs++;
    if (cnt2 !== 4'hF) begin errs++; $display("FAIL st_saturate: got %0d want 15", cnt2); end
    start[2] = 1'b1; tick(); start[2] = 1'b0;
    vecs++;
    if (dv[2] !== 1'b0) begin errs++; $display("FAIL st_valid21: got %b want 0", dv[2]); end
    tick();
    vecs++;
    if (dv[2] !== 1'b1) begin errs++; $display("FAIL st_valid22: got %b want 1", dv[2]); end
    run_to(24);
    start[2] = 1'b1; tick(); start[2] = 1'b0;
    run_to(70);
    vecs++;
    if (xq.size() != 13) begin errs++; $display("FAIL st_count: got %0d want 13", xq.size()); end
    else begin
      vecs++;
      if (xq[0].e != 23 || xq[12].d !== rf[12]) begin
        errs++; $display("FAIL st_entries: got e0=%0d d12=%h want 23/%h", xq[0].e, xq[12].d, rf[12]);
      end
    end
    vecs++;
    if (dq.size() != 1 || dq[0] != 47) begin errs++; $display("FAIL st_done: got n=%0d want 1 at 47", dq.size()); end
  endtask

  task automatic test_reset_mid();
    sel = 0; rf_linear(); do_reset();
    run_to(29);
    vecs++;
    if ({dv[0], didx[0]} !== {1'b1, 5'd7}) begin errs++; $display("FAIL rm_pre: got %b/%0d want 1/7", dv[0], didx[0]); end
    #2 rst = 1'b1;
    #1;
    vecs++;
    if ({dv[0], busy[0], cnt0} !== {2'b00, 16'd0}) begin
      errs++; $display("FAIL rm_async: got valid=%b busy=%b cnt=%0d want 0/0/0", dv[0], busy[0], cnt0);
    end
    @(negedge clk);
    rst = 1'b0; edge_n = 0; xq.delete(); dq.delete();
    run_to(45);
    vecs++;
    if (xq.size() != 13 || xq[0].e != 16 || xq[0].idx !== 5'd0 || xq[12].e != 40) begin
      errs++; $display("FAIL rm_restart: got n=%0d e0=%0d want 13 starting at 16", xq.size(), (xq.size() > 0) ? xq[0].e : -1);
    end
  endtask

  task automatic test_single();
    sel = 3; do_reset();
    rf[0] = $urandom;
    while (edge_n < 20) begin
      tick();
      if (edge_n == 4) begin
        vecs++;
        if ({dv[3], didx[3]} !== {1'b1, 5'd0}) begin errs++; $display("FAIL one_valid: got %b/%0d want 1/0", dv[3], didx[3]); end
      end
      if (edge_n == 6) begin
        vecs++;
        if (busy[3] !== 1'b0) begin errs++; $display("FAIL one_halt: busy=%b want 0", busy[3]); end
      end
    end
    vecs++;
    if (xq.size() != 1 || xq[0].e != 5 || xq[0].d !== rf[0]) begin
      errs++; $display("FAIL one_xfer: got n=%0d want 1 at edge 5 data %h", xq.size(), rf[0]);
    end
    vecs++;
    if (dq.size() != 1 || dq[0] != 5) begin errs++; $display("FAIL one_done: got n=%0d want 1 at 5", dq.size()); end
  endtask

  task automatic test_random_bp();
    logic        stall;
    logic [4:0]  hi;
    logic [31:0] hd;
    sel = 0; do_reset();
    for (int k = 0; k < 32; k++) rf[k] = $urandom;
    while (dq.size() == 0 && edge_n < 400) begin
      rdy[0] = 1'($urandom_range(0, 1));
      stall = dv[0] && !rdy[0];
      hi = didx[0]; hd = ddata[0];
      tick();
      if (stall && ({dv[0], didx[0], ddata[0]} !== {1'b1, hi, hd})) begin
        vecs++; errs++;
        $display("FAIL rnd_hold@%0d: got %b/%0d/%h want 1/%0d/%h", edge_n, dv[0], didx[0], ddata[0], hi, hd);
      end
    end
    rdy[0] = 1'b1;
    vecs++;
    if (xq.size() != 13) begin errs++; $display("FAIL rnd_count: got %0d want 13", xq.size()); end
    for (int k = 0; k < 13 && k < xq.size(); k++) begin
      vecs++;
      if (xq[k].idx !== 5'(k) || xq[k].d !== rf[k]) begin
        errs++; $display("FAIL rnd_entry%0d: got %0d/%h want %0d/%h", k, xq[k].idx, xq[k].d, k, rf[k]);
      end
    end
    vecs++;
    if (dq.size() != 1 || xq.size() == 0 || dq[0] != xq[xq.size()-1].e) begin
      errs++; $display("FAIL rnd_done: got n=%0d want one pulse right after last accept", dq.size());
    end
  endtask

  initial begin
    vecs = 0; errs = 0; edge_n = 0; sel = 0;
    rst = 1'b1; start = '0; rdy = '1;
    for (int k = 0; k < 32; k++) rf[k] = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_periodic();
    test_start();
    test_reset_mid();
    test_single();
    test_random_bp();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
